// File: rtl/serial_arith_pkg.sv
// Shared definitions for the bit-serial arithmetic blocks.
// Contents:
//   state_e      controller FSM encoding (IDLE, SHIFT, DONE)
//   cnt_width()  bit-count register width for a given operand width
//   DEF_WIDTH    default operand width
//   DEF_CNT_W    bit-count width for DEF_WIDTH
package serial_arith_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    // The counter indexes bits 0..w-1; the floor of 1 keeps the w=1 corner legal.
    function automatic int unsigned cnt_width(input int unsigned w);
        return (w < 2) ? 1 : $clog2(w);
    endfunction

    localparam int unsigned DEF_WIDTH = 8;
    localparam int unsigned DEF_CNT_W = cnt_width(DEF_WIDTH);

endpackage

// File: rtl/fa_bit_cell.sv
// Combinational 1-bit full adder: the single arithmetic cell that the serial
// controller time-shares across all bit positions.
// Ports:
//   a, b  operand bits
//   ci    carry in
//   s     sum bit
//   co    carry out
module fa_bit_cell (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    logic w_p;

    assign w_p = a ^ b;
    assign s   = w_p ^ ci;
    assign co  = (a & b) | (ci & w_p);

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller. Captures two WIDTH-bit operands over a
// valid/ready handshake, adds them LSB first one bit per clock through a
// single full-adder cell and a carry flip-flop, then holds the result on a
// valid/ready output until the consumer takes it.
// Optional feature: define SERIAL_ADD_SUB_EN to add the op_sub input, which
// turns the operation into a - b (b inverted, carry-in forced to 1; cin is
// ignored, cout=1 means no borrow).
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   in_valid / in_ready   operand handshake
//   a, b, cin             operands and carry-in, captured at accept
//   op_sub                subtract select (SERIAL_ADD_SUB_EN only)
//   out_valid / out_ready result handshake
//   sum, cout             result, stable from DONE entry until next DONE entry
//   busy                  high whenever the FSM is not in IDLE
module serial_add_ctrl
    import serial_arith_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_ADD_SUB_EN
    input  logic             op_sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);

    localparam int unsigned CNT_W = cnt_width(WIDTH);

    state_e             r_state;
    state_e             w_state_nxt;
    logic [WIDTH-1:0]   r_a_sh;
    logic [WIDTH-1:0]   r_b_sh;
    logic [WIDTH-1:0]   r_sum_sh;
    logic [WIDTH-1:0]   w_sum_sh_nxt;
    logic               r_carry;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_sum;
    logic               r_cout;
    logic               r_in_ready;
    logic               r_out_valid;
    logic               r_busy;
    logic               w_accept;
    logic               w_release;
    logic               w_last;
    logic               w_s;
    logic               w_co;
    logic [WIDTH-1:0]   w_b_load;
    logic               w_carry_load;

    assign w_accept     = in_valid & r_in_ready;
    assign w_release    = r_out_valid & out_ready;
    assign w_last       = (r_cnt == CNT_W'(WIDTH - 1));
    assign w_sum_sh_nxt = {w_s, r_sum_sh[WIDTH-1:1]};

    // Operand B and initial carry as loaded at accept.
`ifdef SERIAL_ADD_SUB_EN
    assign w_b_load     = op_sub ? ~b : b;
    assign w_carry_load = op_sub ? 1'b1 : cin;
`else
    assign w_b_load     = b;
    assign w_carry_load = cin;
`endif

    // The one shared full-adder cell, fed from the LSBs of the operand shifters.
    fa_bit_cell u_cell (
        .a  (r_a_sh[0]),
        .b  (r_b_sh[0]),
        .ci (r_carry),
        .s  (w_s),
        .co (w_co)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_accept)  w_state_nxt = SHIFT;
            SHIFT:   if (w_last)    w_state_nxt = DONE;
            DONE:    if (w_release) w_state_nxt = IDLE;
            default:                w_state_nxt = IDLE;
        endcase
    end

    // Handshake and status flags, registered from the next state so they line
    // up with the state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_in_ready  <= (w_state_nxt == IDLE);
            r_out_valid <= (w_state_nxt == DONE);
            r_busy      <= (w_state_nxt != IDLE);
        end
    end

    // Serial datapath: operand capture, bit shifting and result latch.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a_sh   <= '0;
            r_b_sh   <= '0;
            r_sum_sh <= '0;
            r_carry  <= 1'b0;
            r_cnt    <= '0;
            r_sum    <= '0;
            r_cout   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_a_sh   <= a;
                        r_b_sh   <= w_b_load;
                        r_carry  <= w_carry_load;
                        r_sum_sh <= '0;
                        r_cnt    <= '0;
                    end
                end
                SHIFT: begin
                    r_sum_sh <= w_sum_sh_nxt;
                    r_a_sh   <= r_a_sh >> 1;
                    r_b_sh   <= r_b_sh >> 1;
                    r_carry  <= w_co;
                    // Counter parks at WIDTH-1 rather than wrapping.
                    if (w_last) begin
                        r_sum  <= w_sum_sh_nxt;
                        r_cout <= w_co;
                    end else begin
                        r_cnt  <= r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign busy      = r_busy;
    assign sum       = r_sum;
    assign cout      = r_cout;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Scoreboard bench for serial_add_ctrl (WIDTH=8). Stimulus pushes the
// hand-computed result of every accepted operation; a monitor pops and
// compares on each output handshake. Directed checks cover reset, latency,
// initiation interval, backpressure, busy-time input masking and mid-flight
// reset. Define SERIAL_ADD_SUB_EN to also exercise subtraction.
module tb_serial_add_ctrl;

    localparam int unsigned W = 8;

    typedef struct packed {
        logic [W-1:0] sum;
        logic         cout;
    } res_t;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
`ifdef SERIAL_ADD_SUB_EN
    logic         op_sub;
`endif
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         busy;

    int   n_checks;
    int   n_errors;
    int   cyc;
    res_t exp_q[$];

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
`ifdef SERIAL_ADD_SUB_EN
        .op_sub    (op_sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Hard stop in case something wedges outside the bounded waits.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got time %0t, required < 200000", $time);
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 'h%0h, required 'h%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present operands, hold in_valid until accepted, push the expected result.
    // Returns one step after the accept edge; acc_cyc is that edge's cycle index
    // and held is how many edges in_valid waited unaccepted.
    task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc,
                        input logic [W-1:0] es, input logic ec, input bit push,
                        output int acc_cyc, output int held);
        res_t e;
        held     = 0;
        in_valid = 1'b1;
        a        = ta;
        b        = tb;
        cin      = tc;
        while (!in_ready && held < 60) begin
            tick();
            held++;
        end
        if (!in_ready) begin
            chk("accept_timeout", 32'(held), 32'd0);
            in_valid = 1'b0;
            acc_cyc  = cyc;
            return;
        end
        chk("accept_in_idle_busy", 32'(busy), 32'd0);
        e.sum  = es;
        e.cout = ec;
        if (push) exp_q.push_back(e);
        @(posedge clk);
        acc_cyc = cyc;
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((busy || out_valid) && n < 60) begin
            tick();
            n++;
        end
        chk("wait_idle_timeout", 32'(busy | out_valid), 32'd0);
    endtask

    // Scoreboard monitor: one compare per output handshake.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_errors++;
                $display("FAIL unexpected_result: got sum='h%0h cout=%0b, required no output", sum, cout);
            end else begin
                res_t e;
                e = exp_q.pop_front();
                if (sum !== e.sum || cout !== e.cout) begin
                    n_errors++;
                    $display("FAIL result: got sum='h%0h cout=%0b, required sum='h%0h cout=%0b",
                             sum, cout, e.sum, e.cout);
                end
            end
        end
    end

    initial begin
        int acc1, acc2, held, lat;
        n_checks  = 0;
        n_errors  = 0;
        cyc       = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        out_ready = 1'b1;
`ifdef SERIAL_ADD_SUB_EN
        op_sub    = 1'b0;
`endif
        repeat (3) tick();
        chk("rst_in_ready",  32'(in_ready),  32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_busy",      32'(busy),      32'd0);
        chk("rst_sum",       32'(sum),       32'd0);
        chk("rst_cout",      32'(cout),      32'd0);
        rst = 1'b0;
        tick();

        // 1: basic add; out_valid seen in the ninth cycle after accept.
        send(8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1, acc1, held);
        lat = 1;
        while (!out_valid && lat < 40) begin
            chk("shift_in_ready_low", 32'(in_ready), 32'd0);
            tick();
            lat++;
        end
        chk("latency", 32'(lat), 32'd9);

        // 2: carry boundaries, issued back to back to measure initiation interval.
        send(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b1, acc2, held);
        chk("init_interval", 32'(acc2 - acc1), 32'd10);
        wait_idle();
        send(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b1, acc1, held);
        wait_idle();
        repeat (3) tick();
        chk("idle_holds_sum",  32'(sum),  32'h0FF);
        chk("idle_holds_cout", 32'(cout), 32'd1);

        // 3: backpressure for 5 cycles in DONE.
        out_ready = 1'b0;
        send(8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b1, acc1, held);
        lat = 0;
        while (!out_valid && lat < 40) begin
            tick();
            lat++;
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_out_valid", 32'(out_valid), 32'd1);
            chk("bp_in_ready",  32'(in_ready),  32'd0);
            chk("bp_sum",       32'(sum),       32'h46);
            chk("bp_cout",      32'(cout),      32'd0);
        end
        out_ready = 1'b1;
        tick();
        chk("bp_release_out_valid", 32'(out_valid), 32'd0);
        chk("bp_release_in_ready",  32'(in_ready),  32'd1);

        // 4: second request held (with new operands) while the first is in flight.
        send(8'h21, 8'h43, 1'b1, 8'h65, 1'b0, 1'b1, acc1, held);
        send(8'h0F, 8'hF0, 1'b0, 8'hFF, 1'b0, 1'b1, acc2, held);
        chk("held_while_busy", 32'(held >= 8), 32'd1);
        wait_idle();

        // 5: reset in the middle of SHIFT drops the operation.
        send(8'hAA, 8'h55, 1'b0, 8'h00, 1'b0, 1'b0, acc1, held);
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_in_ready",  32'(in_ready),  32'd1);
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_busy",      32'(busy),      32'd0);
        chk("midrst_sum",       32'(sum),       32'd0);
        chk("midrst_cout",      32'(cout),      32'd0);
        repeat (12) tick();
        chk("midrst_no_valid", 32'(out_valid), 32'd0);
        send(8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b1, acc1, held);
        wait_idle();

`ifdef SERIAL_ADD_SUB_EN
        // 6: subtraction; cin is ignored, cout=1 means no borrow.
        op_sub = 1'b1;
        send(8'h10, 8'h01, 1'b0, 8'h0F, 1'b1, 1'b1, acc1, held);
        wait_idle();
        send(8'h01, 8'h02, 1'b1, 8'hFF, 1'b0, 1'b1, acc1, held);
        wait_idle();
        op_sub = 1'b0;
        send(8'h5A, 8'h3C, 1'b1, 8'h97, 1'b0, 1'b1, acc1, held);
        wait_idle();
`endif

        lat = 0;
        while (exp_q.size() != 0 && lat < 40) begin
            tick();
            lat++;
        end
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
